spi_target_frontend: RTL

- Byte-level SPI target (peripheral) front end.
- Oversamples the MCU's SPI pins (mode 0, MSB first) in the system clock domain and presents each transaction to the register block as an opcode followed by numbered operand bytes.
- Shifts the register block's response bytes back out on the data-out pin.
- Sits between the FPGA SPI pins and the camera/display register blocks.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_pin_synchronizer.sv | 32 +++
 rtl/spi_target_frontend.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared states and constants for the SPI target front end.
package spi_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned BIT_W   = $clog2(BYTE_W);
   localparam int unsigned COUNT_W = 32;
   localparam int unsigned CNT_W   = COUNT_W - 1;

   // Byte shifted out when the register block has nothing to say.
   localparam logic [BYTE_W-1:0] IDLE_FILL = BYTE_W'(0);
   localparam logic [CNT_W-1:0]  COUNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_OPCODE        = 2'd1,
      ST_OPERAND       = 2'd2,
      ST_WAIT_DESELECT = 2'd3
   } state_e;

endpackage

// File: rtl/spi_pin_synchronizer.sv
// spi_pin_synchronizer: flop chain for one asynchronous SPI pin plus
// rise/fall flags formed from the last two synchronized samples.
module spi_pin_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o_c,
   output logic fall_o_c
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   // Shift the pin through the chain; prev_q holds the previous synchronized sample.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         chain_q <= STAGES'({chain_q, pin_i});
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign level_o  = chain_q[STAGES-1];
   assign rise_o_c = chain_q[STAGES-1] & ~prev_q;
   assign fall_o_c = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target_frontend.sv
// spi_target_frontend: byte-level SPI mode-0 target. Pins are oversampled on
// clock_in; each transaction is presented as an opcode plus numbered operands,
// and response bytes are shifted back out on CIPO.
module spi_target_frontend
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned TX_LOAD_DELAY = 2
) (
   input  logic               clock_in,
   input  logic               reset_n_in,
   input  logic               spi_select_in,
   input  logic               spi_clock_in,
   input  logic               spi_data_in,
   output logic               spi_data_out,
   output logic [BYTE_W-1:0]  op_code_out,
   output logic               op_code_valid_out,
   output logic [BYTE_W-1:0]  operand_out,
   output logic               operand_valid_out,
   output logic [COUNT_W-1:0] operand_count_out,
   input  logic [BYTE_W-1:0]  response_in,
   input  logic               response_valid_in
);

   localparam int unsigned LOAD_W = (TX_LOAD_DELAY < 1) ? 1 : $clog2(TX_LOAD_DELAY + 1);

   logic sel, sck_rise, sck_fall, mosi;
   logic sel_rise, sel_fall, sck_level, mosi_rise, mosi_fall;
   logic unused_edges;

   state_e             state_q, state_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]  rx_shift_q, rx_shift_d;
   logic               byte_done_q, byte_done_d;
   logic [BYTE_W-1:0]  tx_shift_q, tx_shift_d;
   logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
   logic [BYTE_W-1:0]  op_code_q, op_code_d;
   logic               op_code_valid_q, op_code_valid_d;
   logic [BYTE_W-1:0]  operand_q, operand_d;
   logic               operand_valid_q, operand_valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               data_out_q, data_out_d;
   logic               load_now;
   logic [BYTE_W-1:0]  rx_byte, resp_byte;

   spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sel (
      .clk_i(clock_in), .rst_ni(reset_n_in), .pin_i(spi_select_in),
      .level_o(sel), .rise_o_c(sel_rise), .fall_o_c(sel_fall)
   );

   spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk_i(clock_in), .rst_ni(reset_n_in), .pin_i(spi_clock_in),
      .level_o(sck_level), .rise_o_c(sck_rise), .fall_o_c(sck_fall)
   );

   spi_pin_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk_i(clock_in), .rst_ni(reset_n_in), .pin_i(spi_data_in),
      .level_o(mosi), .rise_o_c(mosi_rise), .fall_o_c(mosi_fall)
   );

   // Select is used as a level and data-in only as a level; their edge flags are sunk here.
   assign unused_edges = ^{sel_rise, sel_fall, sck_level, mosi_rise, mosi_fall};

   // Next-state logic: byte assembly, response load scheduling and deselect handling.
   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      rx_shift_d      = rx_shift_q;
      byte_done_d     = byte_done_q;
      tx_shift_d      = tx_shift_q;
      load_cnt_d      = load_cnt_q;
      op_code_d       = op_code_q;
      op_code_valid_d = op_code_valid_q;
      operand_d       = operand_q;
      operand_valid_d = operand_valid_q;
      count_d         = count_q;
      data_out_d      = data_out_q;
      load_now        = 1'b0;
      rx_byte         = {rx_shift_q[BYTE_W-2:0], mosi};
      resp_byte       = response_valid_in ? response_in : IDLE_FILL;

      case (state_q)
         ST_IDLE: begin
            if (!sel) state_d = ST_OPCODE;
         end
         // Reset can land mid-transaction; stay deaf until the host releases select.
         ST_WAIT_DESELECT: begin
            if (sel) state_d = ST_IDLE;
         end
         default: begin
            if (sel) begin
               // Deselect wins over any SCK edge and discards partial bytes.
               state_d         = ST_IDLE;
               bit_cnt_d       = '0;
               rx_shift_d      = '0;
               byte_done_d     = 1'b0;
               tx_shift_d      = '0;
               load_cnt_d      = '0;
               op_code_d       = '0;
               op_code_valid_d = 1'b0;
               operand_d       = '0;
               operand_valid_d = 1'b0;
               count_d         = '0;
               data_out_d      = 1'b0;
            end else begin
               if (load_cnt_q != '0) begin
                  load_cnt_d = load_cnt_q - LOAD_W'(1);
                  load_now   = (load_cnt_q == LOAD_W'(1));
               end
               if (sck_rise) begin
                  rx_shift_d = rx_byte;
                  bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
                     byte_done_d = 1'b1;
                     if (state_q == ST_OPCODE) begin
                        op_code_d       = rx_byte;
                        op_code_valid_d = 1'b1;
                     end else begin
                        operand_d       = rx_byte;
                        operand_valid_d = 1'b1;
                     end
                  end
               end else if (sck_fall) begin
                  if (byte_done_q) begin
                     // Byte boundary: retire the operand and schedule the next response byte.
                     byte_done_d = 1'b0;
                     state_d     = ST_OPERAND;
                     if (state_q == ST_OPERAND) begin
                        operand_valid_d = 1'b0;
                        if (count_q != COUNT_MAX) count_d = count_q + CNT_W'(1);
                     end
                     if (TX_LOAD_DELAY == 0) load_now = 1'b1;
                     else                    load_cnt_d = LOAD_W'(TX_LOAD_DELAY);
                  end else begin
                     tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
                     data_out_d = tx_shift_q[BYTE_W-2];
                  end
               end
               if (load_now) begin
                  tx_shift_d = resp_byte;
                  data_out_d = resp_byte[BYTE_W-1];
               end
            end
         end
      endcase
   end

   // State and output registers; reset waits for a deselect before decoding.
   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q         <= ST_WAIT_DESELECT;
         bit_cnt_q       <= '0;
         rx_shift_q      <= '0;
         byte_done_q     <= 1'b0;
         tx_shift_q      <= '0;
         load_cnt_q      <= '0;
         op_code_q       <= '0;
         op_code_valid_q <= 1'b0;
         operand_q       <= '0;
         operand_valid_q <= 1'b0;
         count_q         <= '0;
         data_out_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         rx_shift_q      <= rx_shift_d;
         byte_done_q     <= byte_done_d;
         tx_shift_q      <= tx_shift_d;
         load_cnt_q      <= load_cnt_d;
         op_code_q       <= op_code_d;
         op_code_valid_q <= op_code_valid_d;
         operand_q       <= operand_d;
         operand_valid_q <= operand_valid_d;
         count_q         <= count_d;
         data_out_q      <= data_out_d;
      end
   end

   assign spi_data_out      = data_out_q;
   assign op_code_out       = op_code_q;
   assign op_code_valid_out = op_code_valid_q;
   assign operand_out       = operand_q;
   assign operand_valid_out = operand_valid_q;
   assign operand_count_out = {1'b0, count_q};

endmodule
